// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: bundles every signal between the bus masters, the arbiter
// and the single external slave.
//
// Handshake: a master raises i_m_cs[k] with its address, write enable and
// write data. It must hold them steady until a cycle in which o_m_ack[k] is
// high. In that cycle the transfer completes, and o_m_dat carries the read
// data. o_m_wait_n[k] is low while a request is outstanding and not yet
// acknowledged. Keeping i_m_cs[k] high after an ack starts the next transfer
// and keeps the bus locked to that master.
//
// Modports:
//   arbiter : the bus_arbiter's own view.
//   master  : the requesters' side (drives i_m_*, sees o_m_* and o_grant).
//   slave   : the external memory side (sees o_addr/o_dat/o_we/o_cs, drives
//             i_dat/i_ack).
// o_dbg_state is the arbiter FSM state (0 = IDLE, 1 = OWNED) for checkers.
interface bus_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8
);
  logic [NUM_MASTERS-1:0]        i_m_cs;
  logic [NUM_MASTERS-1:0]        i_m_we;
  logic [NUM_MASTERS*ADDR_W-1:0] i_m_addr;
  logic [NUM_MASTERS*DATA_W-1:0] i_m_dat;
  logic [DATA_W-1:0]             o_m_dat;
  logic [NUM_MASTERS-1:0]        o_m_ack;
  logic [NUM_MASTERS-1:0]        o_m_wait_n;
  logic [NUM_MASTERS-1:0]        o_grant;
  logic [ADDR_W-1:0]             o_addr;
  logic [DATA_W-1:0]             o_dat;
  logic                          o_we;
  logic                          o_cs;
  logic [DATA_W-1:0]             i_dat;
  logic                          i_ack;
  logic                          o_timeout;
  logic                          o_dbg_state;

  modport arbiter (
    input  i_m_cs, i_m_we, i_m_addr, i_m_dat, i_dat, i_ack,
    output o_m_dat, o_m_ack, o_m_wait_n, o_grant, o_addr, o_dat, o_we, o_cs,
    output o_timeout, o_dbg_state
  );

  modport master (
    output i_m_cs, i_m_we, i_m_addr, i_m_dat,
    input  o_m_dat, o_m_ack, o_m_wait_n, o_grant
  );

  modport slave (
    input  o_addr, o_dat, o_we, o_cs,
    output i_dat, i_ack
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: N-master, single-slave system bus arbiter.
//
// Arbitration uses either fixed priority (MODE 0, index 0 highest) or
// round-robin (MODE 1, the search starts after the last owner). The grant is
// registered, so a request from IDLE reaches the slave one cycle later. An
// owner keeps the bus for as long as it holds cs high (bus lock). A slave that
// never acknowledges is cut off after TIMEOUT cycles with a synthetic ack that
// returns all-ones read data.
//
// Ports:
//   i_clk      system clock
//   i_reset_n  asynchronous active-low reset
//   bus        bus_arbiter_if.arbiter (master requests, slave mux, grant,
//              timeout pulse, debug state)
module bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int MODE        = 0,
  parameter int TIMEOUT     = 255
) (
  input logic           i_clk,
  input logic           i_reset_n,
  bus_arbiter_if.arbiter bus
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   owner_req;
  logic                   timeout_hit;
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic [IDX_W-1:0]       cand;
  int                     start_i;
  logic [NUM_MASTERS-1:0] ack_vec;

  // Owner status and timeout detection. A real ack in the same cycle always
  // beats the timeout.
  always_comb begin
    owner_req   = |(grant_q & bus.i_m_cs);
    timeout_hit = (TIMEOUT != 0) && (state_q == ST_OWNED) && owner_req &&
                  !bus.i_ack && (cnt_q == CNT_LAST);
    // The master that just timed out sits out the edge that releases it,
    // so a stuck master cannot immediately win the bus back.
    req = bus.i_m_cs;
    if (timeout_hit) req = req & ~grant_q;
  end

  // Candidate winner over the current requests. In round-robin mode the
  // search starts one past the last owner and wraps.
  always_comb begin
    pick_grant = '0;
    pick_idx   = '0;
    pick_any   = 1'b0;
    cand       = '0;
    start_i    = (MODE == 1) ? ((int'(last_q) + 1) % NUM_MASTERS) : 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = IDX_W'((start_i + i) % NUM_MASTERS);
      if (!pick_any && req[cand]) begin
        pick_any         = 1'b1;
        pick_idx         = cand;
        pick_grant[cand] = 1'b1;
      end
    end
  end

  // Next-state logic. In OWNED, the grant holds while the owner keeps cs high
  // and no timeout fires. Otherwise the arbiter re-arbitrates in the same
  // edge, so a release hands the bus over with no idle cycle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_OWNED;
          grant_d = pick_grant;
          last_d  = pick_idx;
        end
      end
      ST_OWNED: begin
        if (owner_req && !timeout_hit) begin
          if (!bus.i_ack && (TIMEOUT != 0)) cnt_d = cnt_q + CNT_W'(1);
        end else if (pick_any) begin
          grant_d = pick_grant;
          last_d  = pick_idx;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Slave mux (an all-zero grant yields all-zero slave signals) and
  // master-side ack/wait routing.
  always_comb begin
    bus.o_addr = '0;
    bus.o_dat  = '0;
    bus.o_we   = 1'b0;
    bus.o_cs   = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        bus.o_addr = bus.o_addr | bus.i_m_addr[k*ADDR_W +: ADDR_W];
        bus.o_dat  = bus.o_dat  | bus.i_m_dat[k*DATA_W +: DATA_W];
        bus.o_we   = bus.o_we   | bus.i_m_we[k];
        bus.o_cs   = bus.o_cs   | bus.i_m_cs[k];
      end
    end
    ack_vec         = grant_q & bus.i_m_cs & {NUM_MASTERS{bus.i_ack | timeout_hit}};
    bus.o_m_ack     = ack_vec;
    bus.o_m_wait_n  = ~bus.i_m_cs | ack_vec;
    bus.o_m_dat     = timeout_hit ? {DATA_W{1'b1}} : bus.i_dat;
    bus.o_grant     = grant_q;
    bus.o_timeout   = timeout_hit;
    bus.o_dbg_state = (state_q == ST_OWNED);
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: three 4-master instances share one clock and reset.
// The instances are fixed priority (long timeout), round-robin, and fixed
// priority with TIMEOUT = 4. Inputs change 1 time unit after the rising edge,
// and outputs are sampled after they settle.
module tb_bus_arbiter;
  localparam int NM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [NM-1:0] exp_q[$];
  logic [NM-1:0] exp_g;

  always #5 clk = ~clk;

  bus_arbiter_if #(.NUM_MASTERS(NM), .ADDR_W(16), .DATA_W(8)) if_fix ();
  bus_arbiter_if #(.NUM_MASTERS(NM), .ADDR_W(16), .DATA_W(8)) if_rr ();
  bus_arbiter_if #(.NUM_MASTERS(NM), .ADDR_W(16), .DATA_W(8)) if_to ();

  bus_arbiter #(.NUM_MASTERS(NM), .ADDR_W(16), .DATA_W(8), .MODE(0), .TIMEOUT(255))
    u_fix (.i_clk(clk), .i_reset_n(rst_n), .bus(if_fix.arbiter));
  bus_arbiter #(.NUM_MASTERS(NM), .ADDR_W(16), .DATA_W(8), .MODE(1), .TIMEOUT(255))
    u_rr (.i_clk(clk), .i_reset_n(rst_n), .bus(if_rr.arbiter));
  bus_arbiter #(.NUM_MASTERS(NM), .ADDR_W(16), .DATA_W(8), .MODE(0), .TIMEOUT(4))
    u_to (.i_clk(clk), .i_reset_n(rst_n), .bus(if_to.arbiter));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    if_fix.i_m_cs = '0; if_fix.i_m_we = '0; if_fix.i_m_addr = '0; if_fix.i_m_dat = '0;
    if_fix.i_dat = '0; if_fix.i_ack = 1'b0;
    if_rr.i_m_cs = '0; if_rr.i_m_we = '0; if_rr.i_m_addr = '0; if_rr.i_m_dat = '0;
    if_rr.i_dat = '0; if_rr.i_ack = 1'b0;
    if_to.i_m_cs = '0; if_to.i_m_we = '0; if_to.i_m_addr = '0; if_to.i_m_dat = '0;
    if_to.i_dat = '0; if_to.i_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_fix.i_m_cs = 4'b1111;
    if_fix.i_m_addr = {16'h3333, 16'h2222, 16'h1111, 16'h0abc};
    repeat (2) tick();
    n_vec++; if (if_fix.o_grant !== 4'b0000) begin n_err++; $display("FAIL rst_grant: got %b want 0000", if_fix.o_grant); end
    n_vec++; if (if_fix.o_cs !== 1'b0) begin n_err++; $display("FAIL rst_cs: got %b want 0", if_fix.o_cs); end
    n_vec++; if (if_fix.o_m_wait_n !== 4'b0000) begin n_err++; $display("FAIL rst_wait_n: got %b want 0000", if_fix.o_m_wait_n); end
    n_vec++; if (if_fix.o_addr !== 16'h0000) begin n_err++; $display("FAIL rst_addr: got %h want 0000", if_fix.o_addr); end
    n_vec++; if (if_fix.o_m_ack !== 4'b0000) begin n_err++; $display("FAIL rst_ack: got %b want 0000", if_fix.o_m_ack); end
    n_vec++; if (if_fix.o_dbg_state !== 1'b0) begin n_err++; $display("FAIL rst_state: got %b want 0", if_fix.o_dbg_state); end
    // Deassert between edges: nothing changes until the next rising edge.
    rst_n = 1'b1;
    #1;
    n_vec++; if (if_fix.o_grant !== 4'b0000) begin n_err++; $display("FAIL rst_release_early: got %b want 0000", if_fix.o_grant); end
    exp_q.push_back(4'b0001);
    tick();
    exp_g = exp_q.pop_front();
    n_vec++; if (if_fix.o_grant !== exp_g) begin n_err++; $display("FAIL rst_first_grant: got %b want %b", if_fix.o_grant, exp_g); end
    n_vec++; if (if_fix.o_cs !== 1'b1) begin n_err++; $display("FAIL rst_first_cs: got %b want 1", if_fix.o_cs); end
    n_vec++; if (if_fix.o_addr !== 16'h0abc) begin n_err++; $display("FAIL rst_first_addr: got %h want 0abc", if_fix.o_addr); end
    n_vec++; if (if_fix.o_dbg_state !== 1'b1) begin n_err++; $display("FAIL rst_first_state: got %b want 1", if_fix.o_dbg_state); end
    if_fix.i_m_cs = '0;
    tick();
    n_vec++; if (if_fix.o_grant !== 4'b0000) begin n_err++; $display("FAIL rst_idle_again: got %b want 0000", if_fix.o_grant); end
  endtask

  task automatic test_fixed_priority();
    if_fix.i_m_addr = {16'h3003, 16'h2002, 16'h1001, 16'h0000};
    if_fix.i_m_dat  = {8'h33, 8'h22, 8'h11, 8'h00};
    if_fix.i_m_we   = 4'b1000;
    if_fix.i_m_cs   = 4'b1010;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b1000);
    tick();
    exp_g = exp_q.pop_front();
    n_vec++; if (if_fix.o_grant !== exp_g) begin n_err++; $display("FAIL fix_grant1: got %b want %b", if_fix.o_grant, exp_g); end
    n_vec++; if (if_fix.o_addr !== 16'h1001) begin n_err++; $display("FAIL fix_addr1: got %h want 1001", if_fix.o_addr); end
    n_vec++; if (if_fix.o_dat !== 8'h11 || if_fix.o_we !== 1'b0) begin n_err++; $display("FAIL fix_dat_we1: got %h/%b want 11/0", if_fix.o_dat, if_fix.o_we); end
    n_vec++; if (if_fix.o_m_wait_n !== 4'b0101) begin n_err++; $display("FAIL fix_wait1: got %b want 0101", if_fix.o_m_wait_n); end
    if_fix.i_ack = 1'b1;
    if_fix.i_dat = 8'h6c;
    #1;
    n_vec++; if (if_fix.o_m_ack !== 4'b0010) begin n_err++; $display("FAIL fix_ack1: got %b want 0010", if_fix.o_m_ack); end
    n_vec++; if (if_fix.o_m_wait_n !== 4'b0111) begin n_err++; $display("FAIL fix_wait_ack1: got %b want 0111", if_fix.o_m_wait_n); end
    n_vec++; if (if_fix.o_m_dat !== 8'h6c) begin n_err++; $display("FAIL fix_rdata: got %h want 6c", if_fix.o_m_dat); end
    tick();
    if_fix.i_ack = 1'b0;
    if_fix.i_m_cs = 4'b1000;
    #1;
    exp_g = exp_q.pop_front();
    n_vec++; if (if_fix.o_grant !== exp_g) begin n_err++; $display("FAIL fix_grant_drop: got %b want %b", if_fix.o_grant, exp_g); end
    n_vec++; if (if_fix.o_cs !== 1'b0) begin n_err++; $display("FAIL fix_cs_drop: got %b want 0", if_fix.o_cs); end
    tick();
    exp_g = exp_q.pop_front();
    n_vec++; if (if_fix.o_grant !== exp_g) begin n_err++; $display("FAIL fix_handoff: got %b want %b", if_fix.o_grant, exp_g); end
    n_vec++; if (if_fix.o_addr !== 16'h3003) begin n_err++; $display("FAIL fix_addr3: got %h want 3003", if_fix.o_addr); end
    n_vec++; if (if_fix.o_dat !== 8'h33 || if_fix.o_we !== 1'b1 || if_fix.o_cs !== 1'b1) begin n_err++; $display("FAIL fix_slave3: got %h/%b/%b want 33/1/1", if_fix.o_dat, if_fix.o_we, if_fix.o_cs); end
    if_fix.i_ack = 1'b1;
    #1;
    n_vec++; if (if_fix.o_m_ack !== 4'b1000) begin n_err++; $display("FAIL fix_ack3: got %b want 1000", if_fix.o_m_ack); end
    tick();
    if_fix.i_ack = 1'b0;
    if_fix.i_m_cs = '0;
    if_fix.i_m_we = '0;
    tick();
    n_vec++; if (if_fix.o_grant !== 4'b0000) begin n_err++; $display("FAIL fix_idle: got %b want 0000", if_fix.o_grant); end
  endtask

  task automatic test_lock();
    if_fix.i_m_addr = {16'h3003, 16'h2002, 16'h1001, 16'h0100};
    if_fix.i_m_cs = 4'b0011;
    tick();
    n_vec++; if (if_fix.o_grant !== 4'b0001) begin n_err++; $display("FAIL lock_grant: got %b want 0001", if_fix.o_grant); end
    for (int t = 0; t < 3; t++) begin
      if_fix.i_m_addr[15:0] = 16'h0100 + 16'(t);
      if_fix.i_ack = 1'b1;
      #1;
      n_vec++; if (if_fix.o_m_ack !== 4'b0001) begin n_err++; $display("FAIL lock_ack%0d: got %b want 0001", t, if_fix.o_m_ack); end
      n_vec++; if (if_fix.o_addr !== 16'h0100 + 16'(t)) begin n_err++; $display("FAIL lock_addr%0d: got %h want %h", t, if_fix.o_addr, 16'h0100 + 16'(t)); end
      tick();
      if_fix.i_ack = 1'b0;
      #1;
      n_vec++; if (if_fix.o_grant !== 4'b0001) begin n_err++; $display("FAIL lock_hold%0d: got %b want 0001", t, if_fix.o_grant); end
      n_vec++; if (if_fix.o_m_wait_n[1] !== 1'b0) begin n_err++; $display("FAIL lock_wait1_%0d: got %b want 0", t, if_fix.o_m_wait_n[1]); end
    end
    if_fix.i_m_cs = 4'b0010;
    tick();
    n_vec++; if (if_fix.o_grant !== 4'b0010) begin n_err++; $display("FAIL lock_release: got %b want 0010", if_fix.o_grant); end
    n_vec++; if (if_fix.o_addr !== 16'h1001) begin n_err++; $display("FAIL lock_addr1: got %h want 1001", if_fix.o_addr); end
    if_fix.i_ack = 1'b1;
    #1;
    n_vec++; if (if_fix.o_m_wait_n[1] !== 1'b1) begin n_err++; $display("FAIL lock_wait1_ack: got %b want 1", if_fix.o_m_wait_n[1]); end
    tick();
    if_fix.i_ack = 1'b0;
    if_fix.i_m_cs = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [NM-1:0] cs;
    for (int i = 0; i < 5; i++) exp_q.push_back(4'b0001 << (i % NM));
    cs = 4'b1111;
    if_rr.i_m_cs = cs;
    tick();
    for (int i = 0; i < 5; i++) begin
      exp_g = exp_q.pop_front();
      n_vec++; if (if_rr.o_grant !== exp_g) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", i, if_rr.o_grant, exp_g); end
      if_rr.i_ack = 1'b1;
      #1;
      n_vec++; if (if_rr.o_m_ack !== exp_g) begin n_err++; $display("FAIL rr_ack%0d: got %b want %b", i, if_rr.o_m_ack, exp_g); end
      tick();
      if_rr.i_ack = 1'b0;
      cs[i % NM] = 1'b0;
      if_rr.i_m_cs = cs;
      #1;
      n_vec++; if (if_rr.o_grant !== exp_g) begin n_err++; $display("FAIL rr_hold%0d: got %b want %b", i, if_rr.o_grant, exp_g); end
      tick();
      cs[i % NM] = 1'b1;
      if_rr.i_m_cs = cs;
    end
    if_rr.i_m_cs = '0;
    tick();
    n_vec++; if (if_rr.o_grant !== 4'b0000) begin n_err++; $display("FAIL rr_idle: got %b want 0000", if_rr.o_grant); end
  endtask

  task automatic test_timeout();
    if_to.i_dat = 8'h5a;
    if_to.i_m_cs = 4'b0011;
    tick();
    for (int c = 1; c <= 3; c++) begin
      n_vec++; if (if_to.o_grant !== 4'b0001) begin n_err++; $display("FAIL to_grant_c%0d: got %b want 0001", c, if_to.o_grant); end
      n_vec++; if (if_to.o_m_ack !== 4'b0000 || if_to.o_timeout !== 1'b0) begin n_err++; $display("FAIL to_early_c%0d: ack %b timeout %b want 0000/0", c, if_to.o_m_ack, if_to.o_timeout); end
      tick();
    end
    n_vec++; if (if_to.o_m_ack !== 4'b0001) begin n_err++; $display("FAIL to_ack: got %b want 0001", if_to.o_m_ack); end
    n_vec++; if (if_to.o_m_dat !== 8'hff) begin n_err++; $display("FAIL to_rdata: got %h want ff", if_to.o_m_dat); end
    n_vec++; if (if_to.o_timeout !== 1'b1) begin n_err++; $display("FAIL to_pulse: got %b want 1", if_to.o_timeout); end
    n_vec++; if (if_to.o_m_wait_n !== 4'b1101) begin n_err++; $display("FAIL to_wait: got %b want 1101", if_to.o_m_wait_n); end
    tick();
    n_vec++; if (if_to.o_grant !== 4'b0010) begin n_err++; $display("FAIL to_regrant: got %b want 0010", if_to.o_grant); end
    n_vec++; if (if_to.o_timeout !== 1'b0) begin n_err++; $display("FAIL to_pulse_end: got %b want 0", if_to.o_timeout); end
    repeat (3) tick();
    // 4th owned cycle of master 1: a real ack here beats the timeout.
    if_to.i_ack = 1'b1;
    #1;
    n_vec++; if (if_to.o_m_ack !== 4'b0010) begin n_err++; $display("FAIL to_both_ack: got %b want 0010", if_to.o_m_ack); end
    n_vec++; if (if_to.o_m_dat !== 8'h5a) begin n_err++; $display("FAIL to_both_rdata: got %h want 5a", if_to.o_m_dat); end
    n_vec++; if (if_to.o_timeout !== 1'b0) begin n_err++; $display("FAIL to_both_pulse: got %b want 0", if_to.o_timeout); end
    tick();
    if_to.i_ack = 1'b0;
    if_to.i_m_cs = 4'b0001;
    #1;
    n_vec++; if (if_to.o_grant !== 4'b0010 || if_to.o_timeout !== 1'b0) begin n_err++; $display("FAIL to_after_ack: got %b/%b want 0010/0", if_to.o_grant, if_to.o_timeout); end
    tick();
    n_vec++; if (if_to.o_grant !== 4'b0001) begin n_err++; $display("FAIL to_back0: got %b want 0001", if_to.o_grant); end
    if_to.i_m_cs = '0;
    tick();
  endtask

  task automatic test_async_reset();
    if_fix.i_m_addr = {16'h3003, 16'h2002, 16'h1001, 16'h0000};
    if_fix.i_m_we = 4'b0010;
    if_fix.i_m_cs = 4'b0010;
    tick();
    n_vec++; if (if_fix.o_grant !== 4'b0010 || if_fix.o_we !== 1'b1 || if_fix.o_cs !== 1'b1) begin n_err++; $display("FAIL ar_pre: got %b/%b/%b want 0010/1/1", if_fix.o_grant, if_fix.o_we, if_fix.o_cs); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (if_fix.o_cs !== 1'b0 || if_fix.o_we !== 1'b0) begin n_err++; $display("FAIL ar_cs_we: got %b/%b want 0/0", if_fix.o_cs, if_fix.o_we); end
    n_vec++; if (if_fix.o_grant !== 4'b0000) begin n_err++; $display("FAIL ar_grant: got %b want 0000", if_fix.o_grant); end
    if_fix.i_ack = 1'b1;
    #1;
    n_vec++; if (if_fix.o_m_ack !== 4'b0000) begin n_err++; $display("FAIL ar_ack: got %b want 0000", if_fix.o_m_ack); end
    n_vec++; if (if_fix.o_m_wait_n !== 4'b1101) begin n_err++; $display("FAIL ar_wait: got %b want 1101", if_fix.o_m_wait_n); end
    if_fix.i_ack = 1'b0;
    if_fix.i_m_cs = '0;
    if_fix.i_m_we = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_fixed_priority();
    test_lock();
    test_round_robin();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Parametrised N-master, single-slave bus arbiter for the system bus. It generalises the fixed two-master (UART master over CPU) scheme to NUM_MASTERS requesters, with selectable fixed-priority or round-robin arbitration. It adds a bus-lock hold, per-master wait/ack routing and a no-ack timeout. It sits between the bus masters (CPU, UART loader, future DMA/VGA) and the external memory bus.

## Interface
- NUM_MASTERS, 2, number of requesters (2..8)
- ADDR_W, 16, address width
- DATA_W, 8, data width
- MODE, 0, 0 = fixed priority (index 0 highest), 1 = round-robin
- TIMEOUT, 255, max cycles granted-and-requesting without i_ack; 0 disables timeout
- i_clk  in  1  system clock
- i_reset_n  in  1  reset, asynchronous, active-low
- i_m_cs  in  NUM_MASTERS  per-master bus request / chip select
- i_m_we  in  NUM_MASTERS  per-master write enable
- i_m_addr  in  NUM_MASTERS*ADDR_W  master k address at [k*ADDR_W +: ADDR_W]
- i_m_dat  in  NUM_MASTERS*DATA_W  master k write data at [k*DATA_W +: DATA_W]
- o_m_dat  out  DATA_W  read data, broadcast to all masters
- o_m_ack  out  NUM_MASTERS  per-master transfer acknowledge
- o_m_wait_n  out  NUM_MASTERS  per-master wait, low = stall
- o_grant  out  NUM_MASTERS  registered one-hot grant (all zero = idle)
- o_addr  out  ADDR_W  slave address
- o_dat  out  DATA_W  slave write data
- o_we  out  1  slave write enable
- o_cs  out  1  slave chip select
- i_dat  in  DATA_W  slave read data
- i_ack  in  1  slave acknowledge
- o_timeout  out  1  one-cycle pulse on timeout

## Operation
- States: IDLE (o_grant == 0) and OWNED (exactly one grant bit set). The grant is registered, giving one cycle of arbitration latency.
- At each posedge, if OWNED and the granted master still has cs high and no timeout fires, the grant is held. This lock lets a master keep the bus across back-to-back transfers by keeping cs high.
- Otherwise the arbiter re-arbitrates over the current i_m_cs:
  - MODE 0: lowest set index wins.
  - MODE 1: search starts at last_owner+1, modulo NUM_MASTERS; first set bit wins; last_owner updates on every new grant.
  - If no request is present, go to IDLE.
- Handoff on release is zero-gap: the owner drops cs at edge n; another master requesting at edge n is granted at edge n.
- Slave side mux:
  - o_addr, o_dat, o_we and o_cs come from the granted master, with o_cs = i_m_cs[g].
  - In IDLE, all four are 0.
- Master side:
  - o_m_ack[k] = o_grant[k] & i_m_cs[k] & (i_ack | timeout_hit).
  - o_m_wait_n[k] = ~i_m_cs[k] | o_m_ack[k].
  - A requesting master that is not granted sees wait low.
- o_m_dat = i_dat normally; all ones during a timeout ack.
- Timeout counter (width $clog2(TIMEOUT+1)):
  - Increments each cycle while OWNED, cs high and i_ack low.
  - Clears on i_ack, on a grant change, or in IDLE.
  - When the count equals TIMEOUT-1 with no i_ack: timeout_hit asserts for that cycle, giving a synthetic ack with o_m_dat all ones, and o_timeout pulses.
  - On the next edge the grant is forcibly released and re-arbitration excludes the timed-out master for that edge only.
- TIMEOUT == 0: counter is inactive and o_timeout stays 0.

## Timing
- Reset (async assert): o_grant = 0, last_owner = NUM_MASTERS-1, counter = 0, o_timeout = 0. Consequently o_cs = o_we = 0, o_addr = o_dat = 0, o_m_ack = 0, and o_m_wait_n = ~i_m_cs.
- Reset deassertion takes effect at the next posedge.
- Reset mid-transfer: the grant clears immediately and o_cs falls combinationally; no ack is generated.
- Request to o_cs: one cycle when IDLE. When another master holds the bus, the wait lasts until that master releases.
- Combinational path: i_ack to o_m_ack / o_m_wait_n within the same cycle.
- Simultaneous events:
  - i_ack and timeout in the same cycle: the real ack wins, o_m_dat = i_dat, and no o_timeout.
  - Release and new request at the same edge: the new master is granted.
- Grant never changes while the owner's cs is high, except on timeout or reset.

## Test plan
- Reset: hold i_reset_n low with all cs = 1 -> o_grant = 0, o_cs = 0, o_m_wait_n = 0; release -> o_grant = 'b0001 one cycle later (MODE 0, 4 masters).
- MODE 0: masters 1 and 3 request together -> grant = 'b0010; master 1 drops cs after i_ack -> grant = 'b1000 at the same edge with no idle cycle; o_addr switches to master 3's address.
- MODE 1: 4 masters request continuously, each drops cs one cycle after its ack, then re-requests -> grant order 0, 1, 2, 3, 0.
- Lock: master 0 holds cs through 3 acked transfers while master 1 requests -> grant stays 'b01 throughout; master 1 sees wait_n = 0 until master 0 releases.
- Timeout (TIMEOUT = 4): master 0 requests and the slave never acks -> in the 4th OWNED cycle o_m_ack[0] = 1, o_m_dat = 8'hFF, o_timeout = 1; next edge the grant moves to requesting master 1.
- Async reset mid-write: grant = 'b10, o_we = 1; assert i_reset_n low between edges -> o_cs and o_we go to 0 immediately and no ack is issued.
